alu_mul_sched: RTL and testbench
================================

// Module: alu_mul_sched
// PURPOSE
//  Sequences a 32x32 low-word multiply (shift-and-add) on the shared EX-stage ALU.
//  Arbitrates ALU ownership between the pipeline EX stage and the multiply sequencer.
//  The pipeline normally has priority. A starvation guard takes the ALU and stalls EX when needed.
//  Sits beside EX. sel_mul drives the EX operand/opcode muxes in front of the ALU.
// PARAMETERS
//  WIDTH      32  operand/result width; also the maximum iteration count
//  MAX_STALL  4   consecutive denied ALU-needing cycles before a forced grant (>=1)
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rst         in   1      synchronous reset, active-high
//  ex_req      in   1      EX stage needs the ALU this cycle
//  mul_start   in   1      start a multiply; honoured only in IDLE
//  mul_abort   in   1      cancel the in-flight multiply (flush); no mul_done
//  mul_a       in   WIDTH  multiplicand, sampled with mul_start
//  mul_b       in   WIDTH  multiplier, sampled with mul_start
//  alu_f       in   WIDTH  ALU result F (combinational from alu_a/alu_b/alu_op)
//  sel_mul     out  1      1: ALU operands/op come from this block this cycle
//  alu_a       out  WIDTH  ALU A operand = acc when sel_mul, else 0
//  alu_b       out  WIDTH  ALU B operand = mcand when sel_mul, else 0
//  alu_op      out  6      `ADD (Header.vh) when sel_mul, else 0
//  ex_stall    out  1      forced grant: EX must hold its instruction this cycle
//  mul_busy    out  1      state != IDLE
//  mul_done    out  1      one-cycle pulse; mul_result valid from this cycle
//  mul_result  out  WIDTH  (mul_a*mul_b) mod 2^WIDTH; held until the next mul_start
// BEHAVIOUR
//  Reset: state=IDLE. acc, mcand, mplr, cnt, wait_cnt, mul_result = 0.
//   All outputs 0 on reset, including mul_done and sel_mul.
//  States: IDLE -> RUN -> DONE -> IDLE. Going straight from IDLE to DONE is allowed.
//  IDLE with mul_start:
//   - acc=0, mcand=mul_a, mplr=mul_b, cnt=0, wait_cnt=0.
//   - Next state is DONE if mul_b==0, else RUN.
//  mul_start outside IDLE is ignored. Operands are not re-sampled.
//  RUN, each cycle, with need = mplr[0] and force = (wait_cnt >= MAX_STALL):
//   - need==0: iteration advances without the ALU.
//   - need==1 and (!ex_req or force): sel_mul=1 and acc<=alu_f (acc+mcand). Iteration advances.
//     wait_cnt<=0.
//   - need==1 and ex_req and !force: no advance. wait_cnt<=wait_cnt+1 (saturates at MAX_STALL).
//  ex_stall = RUN & need & ex_req & force. EX loses the ALU only in this case.
//  Advancing an iteration does: mcand<<=1, mplr>>=1, cnt<=cnt+1.
//   Next state is DONE when (mplr>>1)==0 or cnt==WIDTH-1, else stay in RUN.
//  Overflow: arithmetic is modulo 2^WIDTH. Carry out of acc and bits shifted out of mcand are discarded.
//  DONE:
//   - mul_done=1 for exactly one cycle.
//   - mul_result is driven from acc, registered on entry to DONE.
//   - Next state is IDLE.
//   - A mul_start presented during DONE is ignored.
//  Latency with no contention: mul_done rises k+1 cycles after the mul_start cycle.
//   k is the index of the highest set bit of mul_b, plus 1. k=0 for mul_b==0.
//  mul_abort: in RUN or DONE, next state is IDLE.
//   - No mul_done. mul_result is unchanged.
//   - Abort wins over DONE entry in the same cycle. Abort in IDLE is a no-op.
//   - If abort and mul_start are high together in IDLE, the start is honoured.
//  rst has priority over every input. Reset mid-RUN discards the operation.
//  sel_mul and ex_stall are combinational from registered state plus ex_req. No path from alu_f.
// TESTING
//  - Reset, then idle: all outputs 0.
//  - a=7, b=0, start at cycle N -> mul_done at N+1, result 0, sel_mul never 1.
//  - a=3, b=5, ex_req=0 -> sel_mul high in the RUN cycles where mplr[0]=1;
//    mul_done at N+4, result 15.
//  - a=0xFFFFFFFF, b=0xFFFFFFFF, ex_req=0 -> 32 RUN cycles, mul_done at N+33, result 0x00000001.
//  - a=2, b=1, ex_req held 1, MAX_STALL=4 -> 4 denied cycles, then ex_stall=sel_mul=1 for 1 cycle;
//    result 2.
//  - b=0x80000000, mul_abort in the 10th RUN cycle -> IDLE next, no mul_done, mul_result retains prior value.
//    A new start then completes normally.

Source files
------------

// File: rtl/alu_mul_sched_if.sv
// Handshake bundle between the EX stage / shared ALU and the multiply sequencer.
// The master side is the pipeline and ALU; the slave side is alu_mul_sched.
interface alu_mul_sched_if #(
    parameter int WIDTH = 32
);
    logic             ex_req;
    logic             mul_start;
    logic             mul_abort;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] alu_f;
    logic             sel_mul;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [5:0]       alu_op;
    logic             ex_stall;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;

    modport master (
        output ex_req, mul_start, mul_abort, mul_a, mul_b, alu_f,
        input  sel_mul, alu_a, alu_b, alu_op, ex_stall, mul_busy, mul_done, mul_result
    );

    modport slave (
        input  ex_req, mul_start, mul_abort, mul_a, mul_b, alu_f,
        output sel_mul, alu_a, alu_b, alu_op, ex_stall, mul_busy, mul_done, mul_result
    );
endinterface

// File: rtl/alu_mul_sched.sv
// Shift-and-add low-word multiplier sharing the EX-stage ALU, with EX priority
// and a starvation guard that forces a grant after MAX_STALL denied cycles.
module alu_mul_sched #(
    parameter int          WIDTH     = 32,
    parameter int          MAX_STALL = 4,
    parameter logic [5:0]  ADD_OP    = 6'h20
) (
    input logic            clk,
    input logic            rst,
    alu_mul_sched_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int SW = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    wait_cnt;
    logic [WIDTH-1:0] mul_result;
    logic             mul_done;
    logic             mul_busy;

    logic need;
    logic force_grant;
    logic grant;
    logic advance;
    logic last_iter;

    // Grant decode depends only on registered state and ex_req, never on alu_f.
    always_comb begin
        need        = mplr[0];
        force_grant = (wait_cnt >= SW'(MAX_STALL));
        grant       = (state == RUN) && need && (!bus.ex_req || force_grant);
        advance     = (state == RUN) && (!need || grant);
        last_iter   = (mplr[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));
    end

    assign bus.sel_mul    = grant;
    assign bus.ex_stall   = (state == RUN) && need && bus.ex_req && force_grant;
    assign bus.alu_a      = grant ? acc   : '0;
    assign bus.alu_b      = grant ? mcand : '0;
    assign bus.alu_op     = grant ? ADD_OP : '0;
    assign bus.mul_done   = mul_done;
    assign bus.mul_busy   = mul_busy;
    assign bus.mul_result = mul_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            mcand      <= '0;
            mplr       <= '0;
            cnt        <= '0;
            wait_cnt   <= '0;
            mul_result <= '0;
            mul_done   <= 1'b0;
            mul_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mul_done <= 1'b0;
                    if (bus.mul_start) begin
                        acc      <= '0;
                        mcand    <= bus.mul_a;
                        mplr     <= bus.mul_b;
                        cnt      <= '0;
                        wait_cnt <= '0;
                        mul_busy <= 1'b1;
                        if (bus.mul_b == '0) begin
                            state      <= DONE;
                            mul_result <= '0;
                            mul_done   <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (bus.mul_abort) begin
                        state    <= IDLE;
                        mul_busy <= 1'b0;
                    end else if (advance) begin
                        mcand <= mcand << 1;
                        mplr  <= mplr >> 1;
                        cnt   <= cnt + CW'(1);
                        if (need) begin
                            acc      <= bus.alu_f;
                            wait_cnt <= '0;
                        end
                        // Result is captured on the final iteration so DONE can present it.
                        if (last_iter) begin
                            state      <= DONE;
                            mul_done   <= 1'b1;
                            mul_result <= need ? bus.alu_f : acc;
                        end
                    end else if (wait_cnt != SW'(MAX_STALL)) begin
                        wait_cnt <= wait_cnt + SW'(1);
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    mul_done <= 1'b0;
                    mul_busy <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    mul_done <= 1'b0;
                    mul_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_sched.sv
// Directed bench for alu_mul_sched with a behavioural ADD-only ALU on the shared bus.
module tb_alu_mul_sched;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lat;
    int   sel_cnt;
    int   stall_cnt;

    alu_mul_sched_if #(.WIDTH(32)) bus ();

    alu_mul_sched #(
        .WIDTH(32),
        .MAX_STALL(4),
        .ADD_OP(6'h20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.alu_f = bus.alu_a + bus.alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ticks until mul_done is seen; lat counts cycles after the start cycle.
    task automatic wait_done(output int cycles);
        cycles = 1;
        tick();
        bus.mul_start = 1'b0;
        bus.mul_abort = 1'b0;
        while (!bus.mul_done && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.ex_req = 1'b0;
        bus.mul_start = 1'b0;
        bus.mul_abort = 1'b0;
        bus.mul_a = '0;
        bus.mul_b = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_sel_mul", 32'(bus.sel_mul), 32'd0);
        chk("rst_ex_stall", 32'(bus.ex_stall), 32'd0);
        chk("rst_busy", 32'(bus.mul_busy), 32'd0);
        chk("rst_done", 32'(bus.mul_done), 32'd0);
        chk("rst_result", bus.mul_result, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);

        // b == 0 goes straight to DONE
        bus.mul_a = 32'd7; bus.mul_b = 32'd0; bus.mul_start = 1'b1;
        wait_done(lat);
        chk("b0_latency", lat, 1);
        chk("b0_result", bus.mul_result, 32'd0);
        chk("b0_sel_mul", 32'(bus.sel_mul), 32'd0);
        tick();
        chk("b0_idle_busy", 32'(bus.mul_busy), 32'd0);
        chk("b0_done_pulse", 32'(bus.mul_done), 32'd0);

        // 3 * 5 step by step
        bus.mul_a = 32'd3; bus.mul_b = 32'd5; bus.mul_start = 1'b1;
        tick();
        bus.mul_start = 1'b0;
        chk("m35_r1_sel", 32'(bus.sel_mul), 32'd1);
        chk("m35_r1_alu_a", bus.alu_a, 32'd0);
        chk("m35_r1_alu_b", bus.alu_b, 32'd3);
        chk("m35_r1_alu_op", 32'(bus.alu_op), 32'h20);
        tick();
        chk("m35_r2_sel", 32'(bus.sel_mul), 32'd0);
        chk("m35_r2_alu_b", bus.alu_b, 32'd0);
        tick();
        chk("m35_r3_sel", 32'(bus.sel_mul), 32'd1);
        chk("m35_r3_alu_a", bus.alu_a, 32'd3);
        chk("m35_r3_alu_b", bus.alu_b, 32'd12);
        chk("m35_r3_done", 32'(bus.mul_done), 32'd0);
        tick();
        chk("m35_done", 32'(bus.mul_done), 32'd1);
        chk("m35_result", bus.mul_result, 32'd15);
        tick();
        chk("m35_done_clear", 32'(bus.mul_done), 32'd0);

        // full-width operands, with a stray start during RUN and during DONE
        bus.mul_a = 32'hFFFF_FFFF; bus.mul_b = 32'hFFFF_FFFF; bus.mul_start = 1'b1;
        tick();
        bus.mul_start = 1'b0;
        lat = 1; sel_cnt = 0; stall_cnt = 0;
        while (!bus.mul_done && lat < 40) begin
            if (bus.sel_mul) sel_cnt++;
            if (bus.ex_stall) stall_cnt++;
            if (lat == 5) begin
                bus.mul_start = 1'b1; bus.mul_a = 32'd5; bus.mul_b = 32'd3;
            end else begin
                bus.mul_start = 1'b0;
            end
            tick();
            lat++;
        end
        chk("ff_latency", lat, 33);
        chk("ff_sel_cycles", sel_cnt, 32);
        chk("ff_no_stall", stall_cnt, 0);
        chk("ff_result", bus.mul_result, 32'h0000_0001);
        bus.mul_start = 1'b1; bus.mul_a = 32'd9; bus.mul_b = 32'd0;
        tick();
        bus.mul_start = 1'b0;
        chk("done_start_ignored", 32'(bus.mul_busy), 32'd0);
        chk("done_start_no_done", 32'(bus.mul_done), 32'd0);

        // starvation guard with EX hogging the ALU
        bus.ex_req = 1'b1;
        bus.mul_a = 32'd2; bus.mul_b = 32'd1; bus.mul_start = 1'b1;
        tick();
        bus.mul_start = 1'b0;
        sel_cnt = 0; stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.sel_mul) sel_cnt++;
            if (bus.ex_stall) stall_cnt++;
            tick();
        end
        chk("starve_denied_sel", sel_cnt, 0);
        chk("starve_denied_stall", stall_cnt, 0);
        chk("starve_force_stall", 32'(bus.ex_stall), 32'd1);
        chk("starve_force_sel", 32'(bus.sel_mul), 32'd1);
        chk("starve_force_alu_b", bus.alu_b, 32'd2);
        tick();
        chk("starve_done", 32'(bus.mul_done), 32'd1);
        chk("starve_result", bus.mul_result, 32'd2);
        chk("starve_stall_clear", 32'(bus.ex_stall), 32'd0);
        bus.ex_req = 1'b0;
        tick();

        // abort in the 10th RUN cycle
        bus.mul_a = 32'd1; bus.mul_b = 32'h8000_0000; bus.mul_start = 1'b1;
        tick();
        bus.mul_start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("abort_busy_before", 32'(bus.mul_busy), 32'd1);
        bus.mul_abort = 1'b1;
        tick();
        bus.mul_abort = 1'b0;
        chk("abort_idle", 32'(bus.mul_busy), 32'd0);
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.mul_done) stall_cnt++;
            tick();
        end
        chk("abort_no_done", stall_cnt, 0);
        chk("abort_result_kept", bus.mul_result, 32'd2);

        // new start after abort
        bus.mul_a = 32'd6; bus.mul_b = 32'd7; bus.mul_start = 1'b1;
        wait_done(lat);
        chk("post_abort_latency", lat, 4);
        chk("post_abort_result", bus.mul_result, 32'd42);
        tick();

        // abort and start together in IDLE: start wins
        bus.mul_a = 32'd4; bus.mul_b = 32'd3; bus.mul_start = 1'b1; bus.mul_abort = 1'b1;
        wait_done(lat);
        chk("start_abort_latency", lat, 3);
        chk("start_abort_result", bus.mul_result, 32'd12);
        tick();

        // reset mid-RUN discards the operation
        bus.mul_a = 32'd5; bus.mul_b = 32'h0000_000F; bus.mul_start = 1'b1;
        tick();
        bus.mul_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.mul_busy), 32'd0);
        chk("midrst_result", bus.mul_result, 32'd0);
        tick();
        chk("midrst_done", 32'(bus.mul_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
